// File: rtl/seven_segment_scan_controller_if.sv
// Frame handshake between the segment-conversion logic (master) and the
// seven-segment scan controller (slave).
interface seven_segment_scan_controller_if #(
  parameter int unsigned Digit_Count   = 4,
  parameter int unsigned Segment_Width = 8
);
  logic [Digit_Count*Segment_Width-1:0] frame_data;
  logic                                 frame_valid;
  logic                                 frame_ready;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/seven_segment_scan_controller.sv
// Double-buffered scan sequencer for a common-anode multi-digit seven-segment display.
// Optional PWM dimming is enabled with SEVEN_SEGMENT_SCAN_BRIGHTNESS_EN.
module seven_segment_scan_controller #(
  parameter int unsigned Digit_Count   = 4,
  parameter int unsigned Segment_Width = 8,
  parameter int unsigned Dwell_Width   = 16,
  parameter int unsigned Blank_Ticks   = 4
) (
  input  logic                     clk,
  input  logic                     async_rst,
  input  logic                     clk_en,
  input  logic [Dwell_Width-1:0]   dwell_ticks,
  input  logic [Digit_Count-1:0]   digit_enable,
`ifdef SEVEN_SEGMENT_SCAN_BRIGHTNESS_EN
  input  logic [3:0]               brightness,
`endif
  seven_segment_scan_controller_if.slave frame_if,
  output logic [Segment_Width-1:0] segments,
  output logic [Digit_Count-1:0]   digit_select,
  output logic                     frame_start
);

  localparam int unsigned IdxW = (Digit_Count > 1) ? $clog2(Digit_Count) : 1;
  localparam int unsigned FrameW = Digit_Count * Segment_Width;
  localparam logic [Dwell_Width-1:0] BlankLast = Dwell_Width'(Blank_Ticks - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StBlank} state_e;

  state_e                   state_q;
  logic [IdxW-1:0]          idx_q;
  logic [Dwell_Width-1:0]   cnt_q;
  logic [Dwell_Width-1:0]   dwell_q;
  logic                     start_q;
  logic [FrameW-1:0]        pending_q;
  logic                     pending_valid_q;
  logic [FrameW-1:0]        shadow_q;

  logic                     accept;
  logic [IdxW-1:0]          first_idx;
  logic [IdxW-1:0]          next_idx;
  logic                     next_found;
  int                       cand;
  logic [Segment_Width-1:0] cur_pat;
  logic                     lit;
  logic [Segment_Width-1:0] seg_d;
  logic [Digit_Count-1:0]   sel_d;

  assign frame_if.frame_ready = ~pending_valid_q;
  assign accept = frame_if.frame_valid & ~pending_valid_q;

  // Lowest enabled digit, and the next enabled digit after idx_q (wrapping).
  always_comb begin
    first_idx  = '0;
    next_idx   = idx_q;
    next_found = 1'b0;
    cand       = 0;
    for (int k = int'(Digit_Count) - 1; k >= 0; k--) begin
      if (digit_enable[k]) first_idx = IdxW'(k);
    end
    for (int k = 1; k <= int'(Digit_Count); k++) begin
      cand = (int'(idx_q) + k) % int'(Digit_Count);
      if (!next_found && digit_enable[IdxW'(cand)]) begin
        next_found = 1'b1;
        next_idx   = IdxW'(cand);
      end
    end
  end

  always_comb begin
    cur_pat = '0;
    for (int k = 0; k < int'(Digit_Count); k++) begin
      if (idx_q == IdxW'(k)) cur_pat = shadow_q[k*Segment_Width +: Segment_Width];
    end
  end

`ifdef SEVEN_SEGMENT_SCAN_BRIGHTNESS_EN
  logic [3:0] pwm_q;

  // PWM phase restarts on every digit so each digit gets the same duty.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      pwm_q <= 4'd0;
    end else if (state_q != StDrive) begin
      pwm_q <= 4'd0;
    end else if (clk_en) begin
      pwm_q <= pwm_q + 4'd1;
    end
  end

  assign lit = (brightness == 4'hF) || (pwm_q < brightness);
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    seg_d = '1;
    sel_d = '1;
    if (state_q == StDrive) begin
      sel_d[idx_q] = 1'b0;
      if (lit) seg_d = ~cur_pat;
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      cnt_q           <= '0;
      dwell_q         <= '0;
      start_q         <= 1'b0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      shadow_q        <= '0;
      segments        <= '1;
      digit_select    <= '1;
      frame_start     <= 1'b0;
    end else begin
      segments     <= seg_d;
      digit_select <= sel_d;
      frame_start  <= start_q;
      start_q      <= 1'b0;

      // accept and promote are mutually exclusive: both depend on pending_valid_q.
      if (accept) begin
        pending_q       <= frame_if.frame_data;
        pending_valid_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (pending_valid_q) begin
            shadow_q        <= pending_q;
            pending_valid_q <= 1'b0;
          end
          if (clk_en && (|digit_enable) && (dwell_ticks != '0)) begin
            state_q <= StDrive;
            idx_q   <= first_idx;
            cnt_q   <= '0;
            dwell_q <= dwell_ticks;
            start_q <= 1'b1;
          end
        end

        StDrive: begin
          if (!digit_enable[idx_q]) begin
            state_q <= StBlank;
            cnt_q   <= '0;
          end else if (clk_en) begin
            if (cnt_q == dwell_q - 1'b1) begin
              state_q <= StBlank;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        StBlank: begin
          if (clk_en) begin
            if (cnt_q == BlankLast) begin
              cnt_q <= '0;
              if (!next_found || (dwell_ticks == '0)) begin
                state_q <= StIdle;
              end else begin
                state_q <= StDrive;
                idx_q   <= next_idx;
                dwell_q <= dwell_ticks;
                // Index wrap marks the frame boundary: the only safe point to swap buffers.
                if (next_idx <= idx_q) begin
                  start_q <= 1'b1;
                  if (pending_valid_q) begin
                    shadow_q        <= pending_q;
                    pending_valid_q <= 1'b0;
                  end
                end
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Self-checking bench for seven_segment_scan_controller; pin traces are predicted from
// the scan rules (dwell/blank durations, enabled-digit order, frame double buffering).
module tb_seven_segment_scan_controller;

  localparam int unsigned DC = 4;
  localparam int unsigned SW = 8;
  localparam int          BLANK = 4;

  logic          clk = 1'b0;
  logic          async_rst = 1'b0;
  logic          clk_en = 1'b0;
  logic [15:0]   dwell_ticks = '0;
  logic [DC-1:0] digit_enable = '0;
  logic [SW-1:0] segments;
  logic [DC-1:0] digit_select;
  logic          frame_start;
`ifdef SEVEN_SEGMENT_SCAN_BRIGHTNESS_EN
  logic [3:0]    brightness = 4'hF;
`endif

  seven_segment_scan_controller_if #(.Digit_Count(DC), .Segment_Width(SW)) fif ();

  seven_segment_scan_controller #(
    .Digit_Count  (DC),
    .Segment_Width(SW),
    .Dwell_Width  (16),
    .Blank_Ticks  (BLANK)
  ) dut (
    .clk         (clk),
    .async_rst   (async_rst),
    .clk_en      (clk_en),
    .dwell_ticks (dwell_ticks),
    .digit_enable(digit_enable),
`ifdef SEVEN_SEGMENT_SCAN_BRIGHTNESS_EN
    .brightness  (brightness),
`endif
    .frame_if    (fif.slave),
    .segments    (segments),
    .digit_select(digit_select),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  int          en_period;
  int          cyc;
  logic [31:0] round_frame [0:3];
  logic [12:0] exp_q [$];

  function automatic logic [12:0] pins();
    return {frame_start, digit_select, segments};
  endfunction

  // One clock; inputs change on the falling edge, outputs are sampled there too.
  task automatic step();
    @(negedge clk);
    cyc++;
    clk_en = (en_period != 0) && ((cyc % en_period) == 0);
  endtask

  task automatic do_reset();
    en_period = 0;
    clk_en = 1'b0;
    fif.frame_valid = 1'b0;
    fif.frame_data = '0;
    digit_enable = '0;
    dwell_ticks = '0;
    async_rst = 1'b1;
    step();
    step();
    async_rst = 1'b0;
    step();
  endtask

  task automatic load_frame(input logic [31:0] data);
    fif.frame_valid = 1'b1;
    fif.frame_data = data;
    step();
    fif.frame_valid = 1'b0;
    step();
  endtask

  task automatic start_scan(input logic [3:0] mask, input int dwell, input int period);
    digit_enable = mask;
    dwell_ticks = 16'(dwell);
    en_period = period;
    cyc = 0;
    clk_en = 1'b1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_start: frame_start not seen within 60 clk, got %b required 1", frame_start);
  endtask

  // Expected pin trace: each enabled digit lit dwell*period clk, then blank BLANK*period clk.
  task automatic build_trace(input logic [3:0] mask, input int dwell, input int period,
                             input int rounds);
    logic       first;
    logic [3:0] sel;
    exp_q.delete();
    for (int r = 0; r < rounds; r++) begin
      first = 1'b1;
      for (int d = 0; d < 4; d++) begin
        if (mask[d]) begin
          sel = 4'b1111;
          sel[d] = 1'b0;
          for (int c = 0; c < dwell * period; c++)
            exp_q.push_back({first && (c == 0), sel, ~round_frame[r][d*8 +: 8]});
          first = 1'b0;
          for (int c = 0; c < BLANK * period; c++) exp_q.push_back(13'h0FFF);
        end
      end
    end
  endtask

  task automatic test_reset();
    fif.frame_valid = 1'b0;
    fif.frame_data = '0;
    #2 async_rst = 1'b1;
    #1;
    n_checks += 4;
    if (segments !== 8'hFF) begin
      n_fail++; $display("FAIL reset_segments: got %h required ff", segments);
    end
    if (digit_select !== 4'hF) begin
      n_fail++; $display("FAIL reset_digit_select: got %b required 1111", digit_select);
    end
    if (frame_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_frame_start: got %b required 0", frame_start);
    end
    if (fif.frame_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_frame_ready: got %b required 1", fif.frame_ready);
    end
    step();
    async_rst = 1'b0;
    step();
    n_checks++;
    if (pins() !== 13'h0FFF) begin
      n_fail++; $display("FAIL reset_idle_pins: got %h required 0fff", pins());
    end
  endtask

  task automatic test_scan_full();
    bit ok;
    int dwell;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      if (pass == 0) begin
        round_frame[0] = {8'h06, 8'h5B, 8'h4F, 8'h66};
        dwell = 3;
      end else begin
        round_frame[0] = $urandom;
        dwell = int'($urandom_range(1, 5));
      end
      round_frame[1] = round_frame[0];
      load_frame(round_frame[0]);
      start_scan(4'b1111, dwell, 1);
      wait_start(ok);
      if (ok) begin
        build_trace(4'b1111, dwell, 1, 2);
        for (int i = 0; i < exp_q.size(); i++) begin
          n_checks++;
          if (pins() !== exp_q[i]) begin
            n_fail++;
            $display("FAIL scan_full[%0d]: got fs/sel/seg %b/%b/%h required %b/%b/%h", i,
                     frame_start, digit_select, segments, exp_q[i][12], exp_q[i][11:8],
                     exp_q[i][7:0]);
          end
          step();
        end
      end
    end
  endtask

  task automatic test_mask_0101();
    bit ok;
    int dwell;
    do_reset();
    round_frame[0] = $urandom;
    for (int r = 1; r < 4; r++) round_frame[r] = round_frame[0];
    dwell = int'($urandom_range(1, 4));
    load_frame(round_frame[0]);
    start_scan(4'b0101, dwell, 1);
    wait_start(ok);
    if (ok) begin
      build_trace(4'b0101, dwell, 1, 3);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (pins() !== exp_q[i]) begin
          n_fail++;
          $display("FAIL mask_0101[%0d]: got fs/sel/seg %b/%b/%h required %b/%b/%h", i,
                   frame_start, digit_select, segments, exp_q[i][12], exp_q[i][11:8],
                   exp_q[i][7:0]);
        end
        step();
      end
    end
  endtask

  task automatic test_single_digit();
    bit ok;
    int dwell;
    logic [3:0] mask;
    do_reset();
    mask = 4'b0001 << $urandom_range(0, 3);
    round_frame[0] = $urandom;
    for (int r = 1; r < 4; r++) round_frame[r] = round_frame[0];
    dwell = int'($urandom_range(1, 3));
    load_frame(round_frame[0]);
    start_scan(mask, dwell, 1);
    wait_start(ok);
    if (ok) begin
      build_trace(mask, dwell, 1, 3);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (pins() !== exp_q[i]) begin
          n_fail++;
          $display("FAIL single_digit[%0d]: got fs/sel/seg %b/%b/%h required %b/%b/%h", i,
                   frame_start, digit_select, segments, exp_q[i][12], exp_q[i][11:8],
                   exp_q[i][7:0]);
        end
        step();
      end
    end
  endtask

  task automatic test_slow_clk_en();
    bit ok;
    do_reset();
    round_frame[0] = $urandom;
    load_frame(round_frame[0]);
    start_scan(4'b1111, 2, 4);
    wait_start(ok);
    if (ok) begin
      build_trace(4'b1111, 2, 4, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (pins() !== exp_q[i]) begin
          n_fail++;
          $display("FAIL slow_clk_en[%0d]: got fs/sel/seg %b/%b/%h required %b/%b/%h", i,
                   frame_start, digit_select, segments, exp_q[i][12], exp_q[i][11:8],
                   exp_q[i][7:0]);
        end
        step();
      end
    end
  endtask

  task automatic test_midframe_update();
    bit ok;
    int rlen;
    int k;
    do_reset();
    round_frame[0] = $urandom;
    round_frame[1] = ~round_frame[0] ^ $urandom_range(0, 255);
    load_frame(round_frame[0]);
    start_scan(4'b1111, 2, 1);
    wait_start(ok);
    if (ok) begin
      build_trace(4'b1111, 2, 1, 2);
      rlen = 4 * (2 + BLANK);
      k = int'($urandom_range(1, rlen - 4));
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (pins() !== exp_q[i]) begin
          n_fail++;
          $display("FAIL midframe[%0d]: got fs/sel/seg %b/%b/%h required %b/%b/%h", i,
                   frame_start, digit_select, segments, exp_q[i][12], exp_q[i][11:8],
                   exp_q[i][7:0]);
        end
        if (i == k || i == rlen) begin
          n_checks++;
          if (fif.frame_ready !== 1'b1) begin
            n_fail++; $display("FAIL midframe_ready_high[%0d]: got %b required 1", i,
                               fif.frame_ready);
          end
        end
        if (i == k + 1 || i == rlen - 2) begin
          n_checks++;
          if (fif.frame_ready !== 1'b0) begin
            n_fail++; $display("FAIL midframe_ready_low[%0d]: got %b required 0", i,
                               fif.frame_ready);
          end
        end
        if (i == k) begin
          fif.frame_valid = 1'b1;
          fif.frame_data = round_frame[1];
        end
        if (i == k + 1) fif.frame_valid = 1'b0;
        step();
      end
    end
  endtask

  task automatic test_mask_drop();
    bit ok;
    int j0;
    logic [12:0] want;
    do_reset();
    round_frame[0] = $urandom;
    load_frame(round_frame[0]);
    start_scan(4'b1111, 6, 1);
    wait_start(ok);
    if (ok) begin
      build_trace(4'b1111, 6, 1, 1);
      j0 = 12;  // third lit sample of digit 1
      for (int j = 0; j <= j0 + 9; j++) begin
        want = (j <= j0 + 1) ? exp_q[j] : 13'h0FFF;
        n_checks++;
        if (pins() !== want) begin
          n_fail++;
          $display("FAIL mask_drop[%0d]: got fs/sel/seg %b/%b/%h required %b/%b/%h", j,
                   frame_start, digit_select, segments, want[12], want[11:8], want[7:0]);
        end
        if (j == j0) digit_enable = 4'b0000;
        step();
      end
      n_checks++;
      if (fif.frame_ready !== 1'b1) begin
        n_fail++; $display("FAIL mask_drop_ready: got %b required 1", fif.frame_ready);
      end
      digit_enable = 4'b1111;
      step();
      n_checks++;
      if ({frame_start, digit_select} !== 5'b0_1111) begin
        n_fail++; $display("FAIL mask_drop_idle: got fs/sel %b/%b required 0/1111",
                           frame_start, digit_select);
      end
      step();
      n_checks++;
      if ({frame_start, digit_select} !== 5'b1_1110) begin
        n_fail++; $display("FAIL mask_drop_restart: got fs/sel %b/%b required 1/1110",
                           frame_start, digit_select);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    round_frame[0] = $urandom | 32'h0000_0001;
    load_frame(round_frame[0]);
    start_scan(4'b1111, 3, 1);
    wait_start(ok);
    fif.frame_valid = 1'b1;
    fif.frame_data = $urandom | 32'h0000_0100;
    step();
    fif.frame_valid = 1'b0;
    #2 async_rst = 1'b1;
    #1;
    n_checks += 2;
    if (segments !== 8'hFF) begin
      n_fail++; $display("FAIL async_rst_segments: got %h required ff", segments);
    end
    if (digit_select !== 4'hF) begin
      n_fail++; $display("FAIL async_rst_digit_select: got %b required 1111", digit_select);
    end
    en_period = 0;
    clk_en = 1'b0;
    step();
    async_rst = 1'b0;
    step();
    n_checks++;
    if (fif.frame_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_rst_ready: got %b required 1", fif.frame_ready);
    end
    // No frame loaded: shadow is cleared and the discarded pending frame must not appear.
    round_frame[0] = '0;
    start_scan(4'b0010, 2, 1);
    wait_start(ok);
    if (ok) begin
      build_trace(4'b0010, 2, 1, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (pins() !== exp_q[i]) begin
          n_fail++;
          $display("FAIL async_rst_shadow[%0d]: got fs/sel/seg %b/%b/%h required %b/%b/%h",
                   i, frame_start, digit_select, segments, exp_q[i][12], exp_q[i][11:8],
                   exp_q[i][7:0]);
        end
        step();
      end
    end
  endtask

`ifdef SEVEN_SEGMENT_SCAN_BRIGHTNESS_EN
  task automatic test_brightness();
    bit ok;
    logic [7:0] want;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      brightness = (pass == 0) ? 4'd8 : 4'd0;
      round_frame[0] = 32'h0000_005B;
      load_frame(round_frame[0]);
      start_scan(4'b0001, 16, 1);
      wait_start(ok);
      if (ok) begin
        for (int i = 0; i < 16; i++) begin
          want = (pass == 0 && i < 8) ? 8'hA4 : 8'hFF;
          n_checks++;
          if ({digit_select, segments} !== {4'b1110, want}) begin
            n_fail++;
            $display("FAIL brightness_%0d[%0d]: got sel/seg %b/%h required 1110/%h", pass, i,
                     digit_select, segments, want);
          end
          step();
        end
      end
    end
    brightness = 4'hF;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail = 0;
    en_period = 0;
    cyc = 0;
    test_reset();
    test_scan_full();
    test_mask_0101();
    test_single_digit();
    test_slow_clk_en();
    test_midframe_update();
    test_mask_drop();
    test_async_reset();
`ifdef SEVEN_SEGMENT_SCAN_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
